// File: rtl/vector_unpacker_if.sv
// Load and element handshake bundle for vector_unpacker.
// The unpacker takes the slave side; producer/consumer logic takes the master side.
interface vector_unpacker_if #(
    parameter int LANES = 4,
    parameter int W     = 16
);
    localparam int IDXW = $clog2(LANES);

    logic                 load_valid;
    logic                 load_ready;
    logic [LANES*W-1:0]   vec_in;
    logic                 elem_valid;
    logic                 elem_ready;
    logic [W-1:0]         elem_out;
    logic [IDXW-1:0]      elem_idx;
    logic                 elem_last;
    logic                 busy;

    modport master (
        output load_valid, vec_in, elem_ready,
        input  load_ready, elem_valid, elem_out, elem_idx, elem_last, busy
    );

    modport slave (
        input  load_valid, vec_in, elem_ready,
        output load_ready, elem_valid, elem_out, elem_idx, elem_last, busy
    );
endinterface

// File: rtl/vector_unpacker.sv
// Parallel-in, element-serial-out vector reader: one vector word in, LANES elements out
// lane 0 first. State updates on the falling edge to line up with the pipeline registers.
module vector_unpacker #(
    parameter int LANES = 4,
    parameter int W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    vector_unpacker_if.slave      bus
);
    localparam int              IDXW     = $clog2(LANES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state_q, state_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic [LANES-1:0][W-1:0]  buf_q;
    logic                     load_acc;
    logic                     elem_acc;

    // Outputs are decoded from state; elem_out only ever muxes the registered buffer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        bus.elem_valid = 1'b0;
        bus.elem_out   = '0;
        bus.elem_idx   = idx_q;
        bus.elem_last  = 1'b0;
        bus.busy       = 1'b0;
        if (state_q == SEND) begin
            bus.elem_valid = 1'b1;
            bus.elem_out   = buf_q[idx_q];
            bus.elem_last  = (idx_q == LAST_IDX);
            bus.busy       = 1'b1;
        end
    end

    // load_ready opens on the last element handshake so a new vector follows with no bubble.
    assign bus.load_ready = !reset && !flush &&
                            ((state_q == IDLE) || (bus.elem_valid && bus.elem_ready && bus.elem_last));
    assign load_acc = bus.load_valid && bus.load_ready;
    assign elem_acc = bus.elem_valid && bus.elem_ready && !flush;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (elem_acc) begin
            if (idx_q != LAST_IDX) begin
                idx_d = idx_q + IDXW'(1);
            end else begin
                state_d = IDLE;
                idx_d   = '0;
            end
        end
        if (load_acc) begin
            state_d = SEND;
            idx_d   = '0;
        end
        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(negedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            // NOTE: the element buffer is a plain register bank, so it is reset to a known zero.
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load_acc) begin
                buf_q <= bus.vec_in;
            end
        end
    end
endmodule

// File: tb/tb_vector_unpacker.sv
// Scoreboard bench for vector_unpacker: a 4x16 instance driven per scenario, plus a 3x8 instance.
module tb_vector_unpacker;
    localparam int LANES = 4;
    localparam int W     = 16;
    localparam int IDXW  = $clog2(LANES);

    localparam logic [LANES*W-1:0] VEC_A = 64'h4444_3333_2222_1111;
    localparam logic [LANES*W-1:0] VEC_B = 64'hDDDD_CCCC_BBBB_AAAA;
    localparam logic [LANES*W-1:0] VEC_F = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [W-1:0]    data;
        logic [IDXW-1:0] idx;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    vector_unpacker_if #(.LANES(LANES), .W(W)) bus ();
    vector_unpacker_if #(.LANES(3),     .W(8)) b3  ();

    vector_unpacker #(.LANES(LANES), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    vector_unpacker #(.LANES(3), .W(8)) dut3 (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .bus   (b3)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   ehs_count;
    exp_t sb[$];

    logic            seen_valid, seen_lready, seen_last, seen_busy;
    logic [W-1:0]    seen_out;
    logic [IDXW-1:0] seen_idx;

    // One cycle: drive at the rising edge, sample 1 ns later, update the scoreboard model.
    task automatic step(input logic lv, input logic [LANES*W-1:0] vin, input logic er,
                        input logic fl, input logic rst);
        logic exp_lr;
        exp_t e;
        @(posedge clk);
        reset          = rst;
        flush          = fl;
        bus.load_valid = lv;
        bus.vec_in     = vin;
        bus.elem_ready = er;
        #1;
        seen_valid  = bus.elem_valid;
        seen_lready = bus.load_ready;
        seen_out    = bus.elem_out;
        seen_idx    = bus.elem_idx;
        seen_last   = bus.elem_last;
        seen_busy   = bus.busy;

        exp_lr = !rst && !fl && (sb.size() == 0 || (er && sb[0].last));
        checks++;
        if (seen_lready !== exp_lr) begin
            errors++;
            $display("FAIL load_ready t=%0t got %b exp %b", $time, seen_lready, exp_lr);
        end
        checks++;
        if (seen_valid !== (sb.size() > 0) || seen_busy !== (sb.size() > 0)) begin
            errors++;
            $display("FAIL valid_busy t=%0t got %b/%b exp %b", $time, seen_valid, seen_busy, sb.size() > 0);
        end
        if (sb.size() > 0) e = sb[0];
        else begin
            e.data = '0; e.idx = '0; e.last = 1'b0;
        end
        checks++;
        if (seen_out !== e.data || seen_idx !== e.idx || seen_last !== e.last) begin
            errors++;
            $display("FAIL element t=%0t got %h/%0d/%b exp %h/%0d/%b", $time,
                     seen_out, seen_idx, seen_last, e.data, e.idx, e.last);
        end

        if (rst || fl) begin
            sb.delete();
        end else begin
            if (sb.size() > 0 && er) begin
                void'(sb.pop_front());
                ehs_count++;
            end
            if (lv && exp_lr) begin
                for (int i = 0; i < LANES; i++) begin
                    e.data = vin[i*W +: W];
                    e.idx  = IDXW'(i);
                    e.last = (i == LANES - 1);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (seen_valid !== 1'b0 || seen_out !== '0 || seen_lready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state valid %b out %h ready %b exp 0/0/0", seen_valid, seen_out, seen_lready);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (seen_lready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release load_ready got %b exp 1", seen_lready);
        end
    endtask

    task automatic test_basic();
        ehs_count = 0;
        step(1'b1, VEC_A, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (seen_out !== 16'h1111 || seen_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency got %h valid %b exp 1111 valid 1", seen_out, seen_valid);
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (seen_out !== 16'h4444 || seen_last !== 1'b1) begin
            errors++;
            $display("FAIL basic_last got %h last %b exp 4444 last 1", seen_out, seen_last);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ehs_count != 4 || seen_valid !== 1'b0 || seen_lready !== 1'b1) begin
            errors++;
            $display("FAIL basic_done hs %0d valid %b ready %b exp 4/0/1", ehs_count, seen_valid, seen_lready);
        end
    endtask

    task automatic test_stall();
        ehs_count = 0;
        step(1'b1, VEC_A, 1'b1, 1'b0, 1'b0);
        step(1'b0, VEC_F, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, VEC_F, 1'b0, 1'b0, 1'b0);
            checks++;
            if (seen_out !== 16'h2222 || seen_idx !== IDXW'(1)) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got %h/%0d exp 2222/1", c, seen_out, seen_idx);
            end
        end
        repeat (4) step(1'b0, VEC_F, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ehs_count != 4 || seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_count hs %0d valid %b exp 4/0", ehs_count, seen_valid);
        end
    endtask

    task automatic test_back_to_back();
        ehs_count = 0;
        step(1'b1, VEC_A, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, VEC_B, 1'b1, 1'b0, 1'b0);
        step(1'b1, VEC_B, 1'b1, 1'b0, 1'b0);
        checks++;
        if (seen_out !== 16'h4444 || seen_lready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got %h ready %b exp 4444 ready 1", seen_out, seen_lready);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (seen_out !== 16'hAAAA || seen_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_bubble got %h valid %b exp aaaa valid 1", seen_out, seen_valid);
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ehs_count != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 8", ehs_count);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        step(1'b1, VEC_A, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, VEC_B, 1'b1, 1'b1, 1'b0);
        checks++;
        if (seen_lready !== 1'b0 || seen_out !== 16'h3333) begin
            errors++;
            $display("FAIL flush_cycle ready %b out %h exp 0/3333", seen_lready, seen_out);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (seen_valid !== 1'b0 || seen_idx !== '0) begin
            errors++;
            $display("FAIL flush_idle valid %b idx %0d exp 0/0", seen_valid, seen_idx);
        end
        step(1'b1, VEC_B, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (seen_out !== 16'hAAAA || seen_idx !== '0) begin
            errors++;
            $display("FAIL flush_restart got %h/%0d exp aaaa/0", seen_out, seen_idx);
        end
        repeat (4) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(1'b1, VEC_B, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, VEC_A, 1'b1, 1'b0, 1'b1);
        step(1'b1, VEC_A, 1'b1, 1'b0, 1'b1);
        checks++;
        if (seen_valid !== 1'b0 || seen_busy !== 1'b0 || seen_out !== '0 || seen_lready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid valid %b busy %b out %h ready %b exp all 0",
                     seen_valid, seen_busy, seen_out, seen_lready);
        end
        step(1'b1, VEC_A, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (seen_out !== 16'h1111 || seen_idx !== '0) begin
            errors++;
            $display("FAIL reset_mid_restart got %h/%0d exp 1111/0", seen_out, seen_idx);
        end
        repeat (4) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_non_pow2();
        logic [7:0] exp3 [3];
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk);
            b3.load_valid = 1'b1;
            b3.vec_in     = 24'h33_22_11;
            b3.elem_ready = 1'b1;
            #1;
            checks++;
            if (b3.load_ready !== 1'b1 || b3.elem_idx !== 2'd0) begin
                errors++;
                $display("FAIL np2_load pass %0d ready %b idx %0d exp 1/0", pass, b3.load_ready, b3.elem_idx);
            end
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                b3.load_valid = 1'b0;
                #1;
                checks++;
                if (b3.elem_valid !== 1'b1 || b3.elem_out !== exp3[i] ||
                    b3.elem_idx !== 2'(i) || b3.elem_last !== (i == 2)) begin
                    errors++;
                    $display("FAIL np2_elem lane %0d got %b/%h/%0d/%b", i,
                             b3.elem_valid, b3.elem_out, b3.elem_idx, b3.elem_last);
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (b3.elem_valid !== 1'b0 || b3.elem_idx !== 2'd0) begin
                errors++;
                $display("FAIL np2_wrap valid %b idx %0d exp 0/0", b3.elem_valid, b3.elem_idx);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        bus.load_valid = 1'b0;
        bus.vec_in     = '0;
        bus.elem_ready = 1'b0;
        b3.load_valid  = 1'b0;
        b3.vec_in      = '0;
        b3.elem_ready  = 1'b0;
        repeat (2) @(negedge clk);

        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_non_pow2();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
